inst_encoder_loader: RTL and testbench
======================================

// Module: inst_encoder_loader
// PURPOSE
// Field-to-RV32I instruction encoder plus sequential program loader; exact inverse of the control decoder.
// Accepts decoded instruction fields (kind, funct3, alt bit, rd/rs1/rs2, imm) over a valid/ready stream and packs each into a 32-bit RV32I word.
// Writes the words to consecutive instruction-memory addresses through the imem debug write port.
// Used by the self-test/bootstrap path to place programs in imem before the CPU is released.
// PARAMETERS
// ADDR_W   10   imem byte-address width; addresses advance by 4
// LEN_W    10   width of the program-length counter
// PORTS
// clk         in   1       system clock, rising edge
// rstn        in   1       asynchronous active-low reset
// start       in   1       one-cycle pulse; latches base_addr/len; ignored unless state==IDLE
// base_addr   in   ADDR_W  first write byte address, must be word aligned (addr[1:0] ignored, forced 0)
// len         in   LEN_W   number of instructions to load
// in_valid    in   1       field bundle valid
// in_ready    out  1       encoder can take a bundle this cycle
// in_kind     in   4       0 LOAD,1 STORE,2 BRANCH,3 JAL,4 JALR,5 LUI,6 AUIPC,7 ARITH,8 ARITH_I, 9-15 illegal
// in_funct3   in   3       funct3 field
// in_alt      in   1       ir[30] select: sub/sra/srai
// in_rd/in_rs1/in_rs2 in 5 register indices
// in_imm      in   32      signed immediate, interpreted per format
// imem_we     out  1       write request (held until accepted)
// imem_busy   in   1       imem stall; write completes on cycle with imem_we && !imem_busy
// imem_addr   out  ADDR_W  write byte address
// imem_wdata  out  32      encoded instruction
// busy        out  1       state==RUN
// done        out  1       one-cycle pulse when the final write completes
// err         out  1       sticky: an illegal kind was seen; cleared by accepted start
// BEHAVIOUR
// Reset (rstn=0, async): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, counters=0.
// FSM IDLE -> RUN on start (len!=0); IDLE -> FIN on start with len==0; RUN -> FIN when written==len; FIN -> IDLE next cycle (done=1 in FIN only).
// in_ready = RUN && accepted<len && (!imem_we || !imem_busy); single-entry output register, no skid beyond it.
// Handshake: bundle accepted when in_valid&&in_ready; encoded word registered, imem_we=1 next cycle (1-cycle latency).
// imem_addr starts at base_addr; +4 after each completed write; wraps modulo 2^ADDR_W silently.
// Accept and completion in the same cycle: register reloads, imem_we stays 1, back-to-back throughput 1 word/cycle.
// Encoding (opcode from kind): LOAD 0000011 I; STORE 0100011 S; BRANCH 1100011 B; JAL 1101111 J; JALR 1100111 I, funct3=000;
//  LUI 0110111 U; AUIPC 0010111 U; ARITH 0110011 R, funct7={1'b0,in_alt,5'b0}; ARITH_I 0010011 I.
// I: imm[11:0]; for ARITH_I funct3 001/101 bits[31:25]={1'b0,in_alt,5'b0}, bits[24:20]=imm[4:0].
// S: {imm[11:5],rs2,rs1,f3,imm[4:0]}; B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11]}; U: imm[31:12]; J: {imm[20],imm[10:1],imm[11],imm[19:12]}.
// Unused fields (rd for S/B, rs1/rs2/funct3 for U/J, rs2 for I) are zero regardless of inputs; imm[0] dropped for B/J.
// Illegal kind: emits NOP 0x00000013, still counts toward len, sets err.
// start while RUN/FIN: ignored. Reset mid-load: everything aborts to reset values; partial imem contents left as-is.
// TESTING
// start base=0x40 len=1, addi x1,x0,5 (kind 8,f3 0,imm 5) -> imem_we at addr 0x40, wdata 0x00500093, done pulse, err=0.
// add x3,x1,x2 then sub x3,x1,x2 back-to-back, imem_busy=0 -> 0x002081B3 @base, 0x402081B3 @base+4, consecutive cycles.
// lui x5,0x12345000; jal x1,+8; beq x1,x2,+16; sw x2,8(x1) -> 0x123452B7, 0x008000EF, 0x00208863, 0x0020A423.
// srai x4,x1,3 with in_rs2=31 garbage -> 0x4030D213; imem_busy held 3 cycles -> wdata/addr stable, in_ready=0 meanwhile.
// kind=12 -> wdata 0x00000013, err=1 sticky until next start; start during RUN ignored; start len=0 -> done next-but-one cycle, no write.
// Assert rstn low mid-load of len=4 after 2 writes -> outputs reset immediately; new start loads from fresh base.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32I instruction fields into 32-bit words and streams them
// into consecutive instruction-memory addresses through the imem debug write port.
module inst_encoder_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_busy,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic [31:0]       enc;
  logic              illegal;
  logic              ready;
  logic              accept;
  logic              complete;

  always_comb begin
    enc     = 32'h0000_0013;
    illegal = 1'b0;
    case (in_kind)
      4'd0: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      4'd1: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      4'd2: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], 7'b1100011};
      4'd3: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      4'd4: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      4'd5: enc = {in_imm[31:12], in_rd, 7'b0110111};
      4'd6: enc = {in_imm[31:12], in_rd, 7'b0010111};
      4'd7: enc = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd8: begin
        // shift-immediates carry funct7 in the upper immediate bits
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        end else begin
          enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        end
      end
      default: begin
        enc     = 32'h0000_0013;
        illegal = 1'b1;
      end
    endcase
  end

  assign ready    = (state_q == RUN) && (acc_q < len_q) && (!we_q || !imem_busy);
  assign accept   = in_valid && ready;
  assign complete = we_q && !imem_busy;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          wr_d    = '0;
          addr_d  = base_addr & ~ADDR_W'(3);
          err_d   = 1'b0;
          state_d = (len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d   = acc_q + 1'b1;
          wdata_d = enc;
          if (illegal) begin
            err_d = 1'b1;
          end
        end
        if (complete) begin
          wr_d   = wr_q + 1'b1;
          addr_d = addr_q + ADDR_W'(4);
        end
        // a new word may load in the same cycle the previous one retires
        we_d = accept || (we_q && imem_busy);
        if (complete && wr_d == len_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == FIN);
  assign err        = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: field-level encoding model plus an
// address/data scoreboard checked on every completed imem write.
module tb_inst_encoder_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LEN_W  = 10;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [2:0]        in_funct3;
  logic              in_alt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic              imem_busy;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  inst_encoder_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we), .imem_busy(imem_busy),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int wr_n     = 0;
  int wr_cyc [64];

  logic [ADDR_W-1:0] q_addr [$];
  logic [31:0]       q_data [$];
  int unsigned       m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Instruction word assembled arithmetically from the RV32I format rules.
  function automatic logic [31:0] model_enc(input int unsigned kind, input int unsigned f3,
                                            input int unsigned alt, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input logic [31:0] imm);
    int unsigned i, r, s1, s2, f, w;
    i  = imm;
    r  = (rd % 32) * 128;
    s1 = (rs1 % 32) * 32768;
    s2 = (rs2 % 32) * 1048576;
    f  = (f3 % 8) * 4096;
    case (kind)
      0: w = (i % 4096) * 1048576 + s1 + f + r + 3;
      1: w = ((i / 32) % 128) * 33554432 + s2 + s1 + f + (i % 32) * 128 + 35;
      2: w = ((i / 4096) % 2) * 32'h8000_0000 + ((i / 32) % 64) * 33554432 + s2 + s1 + f
             + ((i / 2) % 16) * 256 + ((i / 2048) % 2) * 128 + 99;
      3: w = ((i / 1048576) % 2) * 32'h8000_0000 + ((i / 2) % 1024) * 2097152
             + ((i / 2048) % 2) * 1048576 + ((i / 4096) % 256) * 4096 + r + 111;
      4: w = (i % 4096) * 1048576 + s1 + r + 103;
      5: w = (i / 4096) * 4096 + r + 55;
      6: w = (i / 4096) * 4096 + r + 23;
      7: w = (alt % 2) * 32'h4000_0000 + s2 + s1 + f + r + 51;
      8: begin
        if (f3 == 1 || f3 == 5) w = (alt % 2) * 32'h4000_0000 + (i % 32) * 1048576 + s1 + f + r + 19;
        else                    w = (i % 4096) * 1048576 + s1 + f + r + 19;
      end
      default: w = 19;
    endcase
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every completed write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rstn && imem_we && !imem_busy) begin
      if (q_addr.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        chk("wr_addr", 32'(imem_addr), 32'(q_addr.pop_front()));
        chk("wr_data", imem_wdata, q_data.pop_front());
        if (wr_n < 64) wr_cyc[wr_n] = cyc;
        wr_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned b, input int unsigned l, input bit model_it);
    base_addr = ADDR_W'(b);
    len       = LEN_W'(l);
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (model_it) m_addr = b & 32'h3FC;
  endtask

  task automatic send(input int unsigned kind, input int unsigned f3, input int unsigned alt,
                      input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
                      input logic [31:0] imm);
    bit got;
    in_kind   = 4'(kind);
    in_funct3 = 3'(f3);
    in_alt    = 1'(alt);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    in_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
      end
    end
    #1;
    if (got) begin
      q_addr.push_back(ADDR_W'(m_addr));
      q_data.push_back(model_enc(kind, f3, alt, rd, rs1, rs2, imm));
      m_addr = (m_addr + 4) % 1024;
    end else begin
      chk_cnt++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk(name, 32'(got), 32'd1);
    @(negedge clk);
    chk({name, "_pulse"}, 32'(done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    tick();
  endtask

  int n0;

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0;
    in_kind = '0; in_funct3 = '0; in_alt = 1'b0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_imm = '0; imem_busy = 1'b0; m_addr = 0;

    // model pinned against hand-assembled words
    chk("pin_addi", model_enc(8, 0, 0, 1, 0, 0, 32'd5),           32'h0050_0093);
    chk("pin_add",  model_enc(7, 0, 0, 3, 1, 2, 32'd0),           32'h0020_81B3);
    chk("pin_sub",  model_enc(7, 0, 1, 3, 1, 2, 32'd0),           32'h4020_81B3);
    chk("pin_lui",  model_enc(5, 0, 0, 5, 0, 0, 32'h1234_5000),   32'h1234_52B7);
    chk("pin_jal",  model_enc(3, 0, 0, 1, 0, 0, 32'd8),           32'h0080_00EF);
    chk("pin_beq",  model_enc(2, 0, 0, 0, 1, 2, 32'd16),          32'h0020_8863);
    chk("pin_sw",   model_enc(1, 2, 0, 0, 1, 2, 32'd8),           32'h0020_A423);
    chk("pin_srai", model_enc(8, 5, 1, 4, 1, 31, 32'd3),          32'h4030_D213);
    chk("pin_ill",  model_enc(12, 3, 1, 7, 7, 7, 32'hFFFF_FFFF),  32'h0000_0013);

    #12;
    chk("rst_we",    32'(imem_we),  32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata,    32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    rstn = 1'b1;
    tick();

    // single addi at 0x40
    do_start(32'h40, 1, 1'b1);
    chk("run_busy", 32'(busy), 32'd1);
    send(8, 0, 0, 1, 0, 0, 32'd5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_we",    32'(imem_we),   32'd1);
    chk("t1_addr",  32'(imem_addr), 32'h40);
    chk("t1_wdata", imem_wdata,     32'h0050_0093);
    wait_done("t1_done");
    chk("t1_err", 32'(err), 32'd0);

    // add then sub, back-to-back
    do_start(32'h60, 2, 1'b1);
    n0 = wr_n;
    send(7, 0, 0, 3, 1, 2, 32'd0);
    send(7, 0, 1, 3, 1, 2, 32'd0);
    in_valid = 1'b0;
    wait_done("t2_done");
    chk("t2_b2b_gap", 32'(wr_cyc[n0 + 1] - wr_cyc[n0]), 32'd1);

    // U/J/B/S formats
    do_start(32'h80, 4, 1'b1);
    send(5, 7, 1, 5, 31, 31, 32'h1234_5000);
    send(3, 7, 0, 1, 9, 9, 32'd8);
    send(2, 0, 0, 17, 1, 2, 32'd16);
    send(1, 2, 0, 21, 1, 2, 32'd8);
    in_valid = 1'b0;
    wait_done("t3_done");

    // srai with imem stalled for three cycles
    do_start(32'h200, 2, 1'b1);
    imem_busy = 1'b1;
    send(8, 5, 1, 4, 1, 31, 32'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_we",    32'(imem_we),   32'd1);
      chk("stall_wdata", imem_wdata,     32'h4030_D213);
      chk("stall_addr",  32'(imem_addr), 32'h200);
      chk("stall_ready", 32'(in_ready),  32'd0);
    end
    tick();
    imem_busy = 1'b0;
    send(8, 0, 0, 2, 0, 0, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    wait_done("t4_done");

    // illegal kind, ignored start during RUN, then len=0 start
    do_start(32'h10, 2, 1'b1);
    send(12, 3, 1, 7, 7, 7, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    tick();
    chk("ill_err", 32'(err), 32'd1);
    do_start(32'h300, 5, 1'b0);
    chk("ign_busy", 32'(busy), 32'd1);
    send(8, 0, 0, 1, 0, 0, 32'd5);
    in_valid = 1'b0;
    wait_done("t5_done");
    chk("ill_err_sticky", 32'(err), 32'd1);
    do_start(32'h0, 0, 1'b1);
    chk("len0_err_clr", 32'(err), 32'd0);
    wait_done("len0_done");

    // reset mid-load after two completed writes
    do_start(32'h100, 4, 1'b1);
    send(7, 0, 0, 3, 1, 2, 32'd0);
    send(13, 0, 0, 0, 0, 0, 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q_addr.size() != 0; i++) @(negedge clk);
    chk("pre_rst_drain", 32'(q_addr.size()), 32'd0);
    chk("pre_rst_err",   32'(err), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_we",    32'(imem_we),   32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd0);
    chk("mid_rst_addr",  32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata,     32'd0);
    chk("mid_rst_err",   32'(err),       32'd0);
    q_addr.delete();
    q_data.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // fresh load across the top of the address space, unaligned base
    do_start(32'h3FE, 2, 1'b1);
    send(5, 0, 0, 5, 0, 0, 32'h1234_5000);
    send(3, 0, 0, 1, 0, 0, 32'd8);
    in_valid = 1'b0;
    wait_done("t6_done");

    chk("scoreboard_empty", 32'(q_addr.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
